fifo_write_arbiter: RTL and testbench

Round-robin write-port arbiter for the dual-clock 8-entry FIFO wrapper. Sits entirely in the clock_1 domain, between NUM_REQ producers and the FIFO's `data_1`/`data_1_en` write port. Grants the port in bounded bursts and never issues a write while `buffer_full` is high. Keeps write and stall statistics for software visibility.

---
 rtl/wrapper_pkg.sv | 14 +
 rtl/fifo_write_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wrapper_pkg.sv
// Shared definitions for the dual-clock FIFO wrapper and its write-side arbiter.
package wrapper_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned BURST_CNT_W = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk the positions start, start+1, ... modulo N and keep the first hit.
  always_comb begin
    int unsigned pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = 32'(start) + 32'(i);
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the FIFO write port, with write/stall statistics.
module fifo_write_arbiter
  import wrapper_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                        clock_1,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        buffer_full,
  output logic [DATA_W-1:0]           data_1,
  output logic                        data_1_en,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            words_written,
  output logic [CNT_W-1:0]            stall_cycles
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t                 state, state_d;
  logic [IDX_W-1:0]       owner, owner_d;
  logic [IDX_W-1:0]       last, last_d;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_d;

  logic [DATA_W-1:0]      req_word [NUM_REQ];
  logic                   owner_valid;
  logic                   xfer;
  logic                   stall;
  logic                   burst_end;
  logic [IDX_W-1:0]       pick_start;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Write/stall qualification for the current owner; full gating is same-cycle.
  always_comb begin
    owner_valid = req_valid[owner];
    xfer        = (state == BURST) && owner_valid && !buffer_full;
    stall       = (state == BURST) && owner_valid && buffer_full;
    burst_end   = (state == BURST) &&
                  (!owner_valid ||
                   (xfer && (burst_cnt == BURST_CNT_W'(MAX_BURST - 1))));
    // Idle searches after the last winner; burst end searches after the owner,
    // which places the owner last in line.
    if (state == IDLE) begin
      pick_start = (last == IDX_W'(NUM_REQ - 1)) ? '0 : last + IDX_W'(1);
    end else begin
      pick_start = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and write-port outputs.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    last_d      = last;
    burst_cnt_d = burst_cnt;
    req_ready   = '0;
    data_1      = '0;
    data_1_en   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_d     = BURST;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        req_ready[owner] = !buffer_full;
        data_1_en        = xfer;
        if (xfer) begin
          data_1      = req_word[owner];
          burst_cnt_d = burst_cnt + BURST_CNT_W'(1);
        end
        if (burst_end) begin
          last_d      = owner;
          burst_cnt_d = '0;
          if (pick_found) begin
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      last      <= last_d;
      burst_cnt <= burst_cnt_d;
    end
  end

  // Statistics: write count wraps, stall count saturates.
  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      words_written <= '0;
      stall_cycles  <= '0;
    end else begin
      if (xfer) begin
        words_written <= words_written + CNT_W'(1);
      end
      if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  assign busy     = (state == BURST);
  assign grant_id = (state == BURST) ? owner : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter; a second instance runs the long stall-saturation case
// in parallel with the write-wrap case on the main instance.
module tb_fifo_write_arbiter;

  logic        clock_1 = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        buffer_full;
  logic [15:0] data_1;
  logic        data_1_en;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] words_written;
  logic [15:0] stall_cycles;

  logic [3:0]  req_valid_b;
  logic [3:0]  req_ready_b;
  logic        buffer_full_b;
  logic [15:0] data_1_b;
  logic        data_1_en_b;
  logic [1:0]  grant_id_b;
  logic        busy_b;
  logic [15:0] words_written_b;
  logic [15:0] stall_cycles_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] word_of [4];

  always #5 clock_1 = ~clock_1;

  fifo_write_arbiter dut (
    .clock_1       (clock_1),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .buffer_full   (buffer_full),
    .data_1        (data_1),
    .data_1_en     (data_1_en),
    .grant_id      (grant_id),
    .busy          (busy),
    .words_written (words_written),
    .stall_cycles  (stall_cycles)
  );

  fifo_write_arbiter dut_b (
    .clock_1       (clock_1),
    .reset         (reset),
    .req_valid     (req_valid_b),
    .req_data      (req_data),
    .req_ready     (req_ready_b),
    .buffer_full   (buffer_full_b),
    .data_1        (data_1_b),
    .data_1_en     (data_1_en_b),
    .grant_id      (grant_id_b),
    .busy          (busy_b),
    .words_written (words_written_b),
    .stall_cycles  (stall_cycles_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [15:0] d,
                         input logic [3:0] rdy, input logic [1:0] g, input logic b);
    chk({tag, "_en"},    32'(data_1_en), 32'(en));
    chk({tag, "_data"},  32'(data_1),    32'(d));
    chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, "_grant"}, 32'(grant_id),  32'(g));
    chk({tag, "_busy"},  32'(busy),      32'(b));
  endtask

  task automatic next();
    @(posedge clock_1);
    #1;
  endtask

  initial begin
    word_of[0] = 16'hA0A0;
    word_of[1] = 16'hB1B1;
    word_of[2] = 16'hC2C2;
    word_of[3] = 16'hD3D3;
    reset         = 1'b1;
    req_valid     = 4'b0000;
    buffer_full   = 1'b0;
    req_valid_b   = 4'b0000;
    buffer_full_b = 1'b0;
    req_data      = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    #2;
    chk_out("rst", 1'b0, 16'h0, 4'b0000, 2'd0, 1'b0);
    chk("rst_ww", 32'(words_written), 32'h0);
    chk("rst_sc", 32'(stall_cycles), 32'h0);
    next();
    next();
    reset = 1'b0;

    // Single requester, three words.
    req_valid = 4'b0001;
    #1;
    chk_out("t1_idle", 1'b0, 16'h0, 4'b0000, 2'd0, 1'b0);
    next();
    for (int k = 0; k < 3; k++) begin
      chk_out("t1_wr", 1'b1, 16'hA0A0, 4'b0001, 2'd0, 1'b1);
      next();
    end
    req_valid = 4'b0000;
    #1;
    chk_out("t1_rel", 1'b0, 16'h0, 4'b0001, 2'd0, 1'b1);
    chk("t1_ww", 32'(words_written), 32'd3);
    next();
    chk_out("t1_done", 1'b0, 16'h0, 4'b0000, 2'd0, 1'b0);

    // Fresh reset, then all four requesters continuously valid.
    reset = 1'b1;
    next();
    reset = 1'b0;
    #1;
    chk("t2_rst_ww", 32'(words_written), 32'h0);
    req_valid = 4'b1111;
    next();
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        chk_out("t2_burst", 1'b1, word_of[b % 4], 4'(4'b0001 << (b % 4)), 2'(b % 4), 1'b1);
        next();
      end
    end
    chk("t2_ww", 32'(words_written), 32'd20);
    req_valid = 4'b0000;
    #1;
    chk_out("t2_rel", 1'b0, 16'h0, 4'b0010, 2'd1, 1'b1);
    next();
    chk("t2_idle", 32'(busy), 32'd0);

    // Full stall in the middle of requester 2's burst.
    req_valid = 4'b0100;
    next();
    for (int k = 0; k < 2; k++) begin
      chk_out("t3_pre", 1'b1, 16'hC2C2, 4'b0100, 2'd2, 1'b1);
      next();
    end
    buffer_full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_out("t3_stall", 1'b0, 16'h0, 4'b0000, 2'd2, 1'b1);
      next();
    end
    buffer_full = 1'b0;
    #1;
    chk("t3_sc", 32'(stall_cycles), 32'd5);
    chk_out("t3_post", 1'b1, 16'hC2C2, 4'b0100, 2'd2, 1'b1);
    next();
    chk_out("t3_post2", 1'b1, 16'hC2C2, 4'b0100, 2'd2, 1'b1);
    next();
    req_valid = 4'b0000;
    #1;
    chk("t3_ww", 32'(words_written), 32'd24);
    chk("t3_sc2", 32'(stall_cycles), 32'd5);
    chk_out("t3_rel", 1'b0, 16'h0, 4'b0100, 2'd2, 1'b1);
    next();
    chk("t3_idle", 32'(busy), 32'd0);

    // Early release: requester 1 drops after one word, 3 waiting.
    req_valid = 4'b0010;
    next();
    req_valid = 4'b1010;
    #1;
    chk_out("t4_r1", 1'b1, 16'hB1B1, 4'b0010, 2'd1, 1'b1);
    next();
    req_valid = 4'b1000;
    #1;
    chk_out("t4_drop", 1'b0, 16'h0, 4'b0010, 2'd1, 1'b1);
    next();
    chk_out("t4_r3", 1'b1, 16'hD3D3, 4'b1000, 2'd3, 1'b1);
    chk("t4_ww", 32'(words_written), 32'd25);
    next();
    req_valid = 4'b0000;
    #1;
    chk_out("t4_rel", 1'b0, 16'h0, 4'b1000, 2'd3, 1'b1);
    next();
    chk("t4_ww2", 32'(words_written), 32'd26);

    // Reset during requester 2's second word.
    req_valid = 4'b0100;
    next();
    chk_out("t5_w1", 1'b1, 16'hC2C2, 4'b0100, 2'd2, 1'b1);
    next();
    chk_out("t5_w2", 1'b1, 16'hC2C2, 4'b0100, 2'd2, 1'b1);
    reset = 1'b1;
    #1;
    chk_out("t5_rst", 1'b0, 16'h0, 4'b0000, 2'd0, 1'b0);
    chk("t5_rst_ww", 32'(words_written), 32'h0);
    chk("t5_rst_sc", 32'(stall_cycles), 32'h0);
    next();
    reset = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("t5_idle", 32'(busy), 32'd0);
    next();
    chk_out("t5_r0", 1'b1, 16'hA0A0, 4'b0001, 2'd0, 1'b1);
    chk("t5_ww", 32'(words_written), 32'h0);
    req_valid = 4'b0000;
    #1;
    next();
    chk("t5_done", 32'(busy), 32'd0);

    // Write-count wrap on the main instance, stall saturation on the second.
    req_valid     = 4'b0001;
    req_valid_b   = 4'b0001;
    buffer_full_b = 1'b1;
    next();
    chk_out("t6_start", 1'b1, 16'hA0A0, 4'b0001, 2'd0, 1'b1);
    chk("t6_b_en", 32'(data_1_en_b), 32'd0);
    chk("t6_b_ready", 32'(req_ready_b), 32'd0);
    chk("t6_b_busy", 32'(busy_b), 32'd1);
    chk("t6_b_data", 32'(data_1_b), 32'd0);
    repeat (65534) next();
    chk("t6_ww_fffe", 32'(words_written), 32'hFFFE);
    chk("t6_sc_fffe", 32'(stall_cycles_b), 32'hFFFE);
    next();
    chk("t6_ww_ffff", 32'(words_written), 32'hFFFF);
    chk("t6_sc_ffff", 32'(stall_cycles_b), 32'hFFFF);
    chk("t6_en", 32'(data_1_en), 32'd1);
    next();
    chk("t6_ww_wrap", 32'(words_written), 32'h0000);
    chk("t6_sc_sat", 32'(stall_cycles_b), 32'hFFFF);
    next();
    chk("t6_ww_one", 32'(words_written), 32'h0001);
    chk("t6_sc_sat2", 32'(stall_cycles_b), 32'hFFFF);
    chk("t6_b_ww", 32'(words_written_b), 32'h0);
    chk("t6_b_grant", 32'(grant_id_b), 32'd0);
    chk("t6_main_sc", 32'(stall_cycles), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
